// File: rtl/scene_radiance_recovery_if.sv
// scene_radiance_recovery_if: atmospheric-light strobe, input pixel beat and output
// radiance beat for the dehaze recovery stage.
interface scene_radiance_recovery_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CH    = 3,
  parameter int unsigned T_W   = 16
) ();
  localparam int unsigned DW = CH * PIX_W;

  logic          atm_valid;
  logic [DW-1:0] atm_pix;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pix;
  logic [T_W-1:0] in_trans;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pix;
  logic [CH-1:0] out_sat;

  // Upstream/downstream side (the pixel source and output writer)
  modport master (
    output atm_valid, atm_pix, in_valid, in_pix, in_trans, out_ready,
    input  in_ready, out_valid, out_pix, out_sat
  );

  // Recovery stage side
  modport slave (
    input  atm_valid, atm_pix, in_valid, in_pix, in_trans, out_ready,
    output in_ready, out_valid, out_pix, out_sat
  );
endinterface

// File: rtl/scene_radiance_recovery.sv
// scene_radiance_recovery: J = A +/- |I - A| / max(t, T_MIN) per channel, saturated,
// through a 3-stage valid/ready pipeline.
// Optional macro SRR_ROUND_EN: round the scaled difference half-up instead of truncating.
module scene_radiance_recovery #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned CH       = 3,
  parameter int unsigned T_W      = 16,
  parameter int unsigned LUT_AW   = 8,
  parameter int unsigned INV_W    = 16,
  parameter int unsigned INV_FRAC = 14,
  parameter int unsigned T_MIN    = 32'h4CCD
) (
  input logic                    clk,
  input logic                    rst,
  scene_radiance_recovery_if.slave bus
);
  localparam int unsigned DW    = CH * PIX_W;
  localparam int unsigned PW    = PIX_W + INV_W;
  localparam int unsigned QW    = PIX_W + INV_W - INV_FRAC;
  localparam int unsigned SW    = QW + 1;
  localparam int unsigned ROM_N = 1 << LUT_AW;
  localparam logic [T_W-1:0]    T_MIN_T   = T_W'(T_MIN);
  localparam logic [LUT_AW-1:0] T_MIN_IDX = T_MIN_T[T_W-1 -: LUT_AW];
`ifdef SRR_ROUND_EN
  localparam logic [PW-1:0] RND = PW'(1) << (INV_FRAC - 1);
`else
  localparam logic [PW-1:0] RND = '0;
`endif

  // Clamped reciprocal of a ROM index, evaluated only at elaboration
  function automatic logic [INV_W-1:0] inv_calc(input int unsigned idx);
    longint unsigned num;
    longint unsigned quo;
    num      = 64'd1 << (INV_FRAC + LUT_AW);
    inv_calc = '1;
    if (idx != 0) begin
      quo = num / 64'(idx);
      if (quo < (64'd1 << INV_W)) inv_calc = INV_W'(quo);
    end
  endfunction

  logic [INV_W-1:0] rom [ROM_N];
  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    localparam logic [INV_W-1:0] ROM_V = inv_calc(g);
    assign rom[g] = ROM_V;
  end

  logic                       ld1_c, ld2_c, ld3_c;
  logic [DW-1:0]              a_q, a_d, a_eff_c;
  logic [LUT_AW-1:0]          idx_c;
  logic                       s1_valid_q, s1_valid_d;
  logic [CH-1:0][PIX_W-1:0]   s1_d_q, s1_d_d;
  logic [CH-1:0]              s1_add_q, s1_add_d;
  logic [DW-1:0]              s1_a_q, s1_a_d;
  logic [INV_W-1:0]           s1_inv_q, s1_inv_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [CH-1:0][QW-1:0]      s2_quo_q, s2_quo_d;
  logic [CH-1:0]              s2_add_q, s2_add_d;
  logic [DW-1:0]              s2_a_q, s2_a_d;
  logic                       out_valid_q, out_valid_d;
  logic [DW-1:0]              out_pix_q, out_pix_d;
  logic [CH-1:0]              out_sat_q, out_sat_d;

  // Stall chain: a stage loads when empty or when its successor loads
  always_comb begin
    ld3_c = !out_valid_q || bus.out_ready;
    ld2_c = !s2_valid_q || ld3_c;
    ld1_c = !s1_valid_q || ld2_c;
  end

  assign bus.in_ready  = ld1_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pix   = out_pix_q;
  assign bus.out_sat   = out_sat_q;

  // A register with same-cycle bypass; stage 1 absolute difference and reciprocal lookup
  always_comb begin
    a_d        = a_q;
    s1_valid_d = s1_valid_q;
    s1_d_d     = s1_d_q;
    s1_add_d   = s1_add_q;
    s1_a_d     = s1_a_q;
    s1_inv_d   = s1_inv_q;
    a_eff_c    = bus.atm_valid ? bus.atm_pix : a_q;
    idx_c      = (bus.in_trans < T_MIN_T) ? T_MIN_IDX : bus.in_trans[T_W-1 -: LUT_AW];
    if (bus.atm_valid) a_d = bus.atm_pix;
    if (ld1_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d   = a_eff_c;
        s1_inv_d = rom[idx_c];
        for (int k = 0; k < CH; k++) begin
          if (bus.in_pix[k*PIX_W +: PIX_W] >= a_eff_c[k*PIX_W +: PIX_W]) begin
            s1_add_d[k] = 1'b1;
            s1_d_d[k]   = bus.in_pix[k*PIX_W +: PIX_W] - a_eff_c[k*PIX_W +: PIX_W];
          end else begin
            s1_add_d[k] = 1'b0;
            s1_d_d[k]   = a_eff_c[k*PIX_W +: PIX_W] - bus.in_pix[k*PIX_W +: PIX_W];
          end
        end
      end
    end
  end

  // Stage 2: scale the difference by the reciprocal; quotient keeps its full integer width
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_quo_d   = s2_quo_q;
    s2_add_d   = s2_add_q;
    s2_a_d     = s2_a_q;
    if (ld2_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_add_d = s1_add_q;
        s2_a_d   = s1_a_q;
        for (int k = 0; k < CH; k++) begin
          s2_quo_d[k] = QW'((PW'(s1_d_q[k]) * PW'(s1_inv_q) + RND) >> INV_FRAC);
        end
      end
    end
  end

  // Stage 3: apply the offset to A and saturate to the pixel range
  always_comb begin
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_sat_d   = out_sat_q;
    if (ld3_c) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        for (int k = 0; k < CH; k++) begin
          if (s2_add_q[k]) begin
            if (SW'(s2_a_q[k*PIX_W +: PIX_W]) + SW'(s2_quo_q[k]) > SW'({PIX_W{1'b1}})) begin
              out_pix_d[k*PIX_W +: PIX_W] = '1;
              out_sat_d[k]                = 1'b1;
            end else begin
              out_pix_d[k*PIX_W +: PIX_W] =
                PIX_W'(SW'(s2_a_q[k*PIX_W +: PIX_W]) + SW'(s2_quo_q[k]));
              out_sat_d[k] = 1'b0;
            end
          end else begin
            if (QW'(s2_a_q[k*PIX_W +: PIX_W]) < s2_quo_q[k]) begin
              out_pix_d[k*PIX_W +: PIX_W] = '0;
              out_sat_d[k]                = 1'b1;
            end else begin
              out_pix_d[k*PIX_W +: PIX_W] =
                PIX_W'(QW'(s2_a_q[k*PIX_W +: PIX_W]) - s2_quo_q[k]);
              out_sat_d[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  // State registers; reset discards in-flight beats and restores A to full scale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q         <= '1;
      s1_valid_q  <= 1'b0;
      s1_d_q      <= '0;
      s1_add_q    <= '0;
      s1_a_q      <= '0;
      s1_inv_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_quo_q    <= '0;
      s2_add_q    <= '0;
      s2_a_q      <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_sat_q   <= '0;
    end else begin
      a_q         <= a_d;
      s1_valid_q  <= s1_valid_d;
      s1_d_q      <= s1_d_d;
      s1_add_q    <= s1_add_d;
      s1_a_q      <= s1_a_d;
      s1_inv_q    <= s1_inv_d;
      s2_valid_q  <= s2_valid_d;
      s2_quo_q    <= s2_quo_d;
      s2_add_q    <= s2_add_d;
      s2_a_q      <= s2_a_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_sat_q   <= out_sat_d;
    end
  end
endmodule

// File: doc/scene_radiance_recovery.md
# scene_radiance_recovery

- Parametrised, back-pressured recovery stage of the dehaze pipeline; computes J = A ± |I − A| / max(t, T_MIN) per colour channel.
- Takes pixels from the transmission-estimation path and delivers saturated radiance pixels to the output writer.
- Compared with the fixed three-channel stage, adds:
  - generic pixel width and channel count;
  - an internal clamped reciprocal ROM;
  - a latched atmospheric-light register;
  - full valid/ready flow control.

## Interface
- PIX_W, 8, bits per channel
- CH, 3, channel count; channel k occupies bits [k*PIX_W +: PIX_W]
- T_W, 16, transmission width, unsigned Q0.T_W
- LUT_AW, 8, reciprocal ROM address width (top LUT_AW bits of clamped t)
- INV_W, 16, reciprocal width, unsigned Q(INV_W−INV_FRAC).INV_FRAC
- INV_FRAC, 14, reciprocal fraction bits
- T_MIN, 16'h4CCD, transmission floor (≈0.3)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- atm_valid  in  1  one-cycle strobe: latch atm_pix
- atm_pix  in  CH*PIX_W  atmospheric light A
- in_valid  in  1  pixel beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_pix  in  CH*PIX_W  hazy pixel I
- in_trans  in  T_W  transmission t
- out_valid  out  1  result beat offered
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_pix  out  CH*PIX_W  recovered pixel J
- out_sat  out  CH  per-channel saturation flag for out_pix

## Operation
- A register: reset value all-ones per channel; loads atm_pix on atm_valid.
  - If atm_valid and an input acceptance occur in the same cycle, the accepted pixel uses the new atm_pix (bypass).
- Stage 1 (on accept):
  - t_c = max(in_trans, T_MIN); idx = t_c[T_W−1 -: LUT_AW].
  - inv = min(2^INV_W−1, floor(2^(INV_FRAC+LUT_AW) / idx)); idx = 0 gives 2^INV_W−1.
  - ROM contents are computed at elaboration, not at run time.
  - Per channel, register d = |I − A| (PIX_W bits), the sign (I ≥ A means add), A, and inv.
- Stage 2: per channel:
  - p = d × inv (PIX_W+INV_W bits);
  - q = p >> INV_FRAC, with rounding per Configuration;
  - q is kept at PIX_W+INV_W−INV_FRAC bits, never truncated to PIX_W.
- Stage 3: per channel:
  - add: J = min(A + q, 2^PIX_W−1);
  - subtract: J = max(A − q, 0);
  - out_sat[k] = 1 when the clamp was applied.
- Flow control:
  - Each stage holds a valid bit; stage k loads when its valid is 0 or stage k+1 loads. The last stage loads when !out_valid || out_ready.
  - in_ready = stage-1 load enable (combinational from out_ready through the stall chain).
  - A stalled stage holds its data and valid unchanged; no beat is dropped or duplicated.
- Reset asserted mid-stream: all valid bits clear immediately, in-flight beats are discarded, and the A register returns to all-ones.

## Timing
- Latency: 3 cycles from accept to out_valid when out_ready is held high; throughput 1 beat/cycle.
- Reset values: out_valid=0, out_pix=0, out_sat=0, all stage valids 0. in_ready=1 while no stage is stalled.
- With out_ready low and the pipeline full, in_ready falls in the same cycle. Up to 3 beats are held.
- When out_ready rises, out_pix updates on the next edge; in_ready rises combinationally.
- atm_valid is honoured regardless of in_ready and stall state; it affects only beats accepted at or after that edge.

## Configuration
- SRR_ROUND_EN:
  - defined: q = (p + 2^(INV_FRAC−1)) >> INV_FRAC (round half up);
  - undefined: q = p >> INV_FRAC (truncate).
- All other behaviour is identical with or without the macro.

## Test plan
- All tests use the defaults; every input beat has t=0x8000 (idx 128, inv 32768 = 2.0) unless stated.
- A=100 latched; I=150 → J=200, sat=0. I=200 → J=255, sat=1. I=50 → J=0, sat=0. I=20 → J=0, sat=1. Each appears exactly 3 cycles after accept.
- t=0x0100 (below T_MIN, so inv=55188), A=100, I=110: J=134 with SRR_ROUND_EN defined, 133 without.
- Back-to-back stream of 16 beats with out_ready toggling randomly: output sequence matches the model in order. in_ready=0 only when 3 beats are held and out_ready=0.
- atm_valid with A=50 in the same cycle as accepting I=100 (t=0x8000): J=150. The previous in-flight beat still uses the old A.
- rst asserted for 1 cycle with 3 beats in flight: out_valid=0 immediately. The A register reads all-ones on the first post-reset beat (A=255, I=255 → J=255).
